// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w
//
// Register file for the single-cycle datapath. It has two combinational read
// ports that feed the ALU operands, one write port that is fed from the
// destination mux, and a debug read port. A saturating counter records the
// number of accepted writes since reset.
//
// Ports:
//   clk       system clock; all state updates occur on the rising edge
//   rst_n     asynchronous active-low reset; clears all registers and the counter
//   we        write enable
//   wa        write address; a write to address 0 is ignored
//   wd        write data
//   ra1/ra2   read addresses for operand ports 1 and 2
//   rd1/rd2   read data; a same-cycle write is forwarded when BYPASS=1
//   dbg_addr  debug read address
//   dbg_data  debug read data; shows stored state only and is never forwarded
//   wr_count  count of accepted writes; saturates at all-ones
// ---------------------------------------------------------------------------
module regfile_2r1w #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              wr_accept;
    logic              fwd_en;

    // A write to register 0 is not a write. It changes neither storage nor the counter.
    assign wr_accept = we && (wa != '0);

    // Forwarding is gated by rst_n so that the read ports also read zero
    // while reset is held, even if a write is pending on the inputs.
    assign fwd_en = (BYPASS != 0) && rst_n && wr_accept;

    always_comb begin
        mem_d = mem_q;
        if (wr_accept) begin
            mem_d[wa] = wd;
        end
        // Register 0 is pinned to zero, so synthesis reduces it to a constant.
        mem_d[0] = '0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (wr_accept && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        rd1 = mem_q[ra1];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (fwd_en && (wa == ra1)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = mem_q[ra2];
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (fwd_en && (wa == ra2)) begin
            rd2 = wd;
        end
    end

    assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// ---------------------------------------------------------------------------
// tb_regfile_2r1w
//
// Testbench for regfile_2r1w. Two copies of the design receive the same
// inputs:
//   - dut_byp uses BYPASS=1 and CNT_W=16.
//   - dut_nb  uses BYPASS=0 and CNT_W=4, so its counter saturates quickly.
//
// Each cycle the stimulus task does three things:
//   1. It updates a behavioural model of the register file.
//   2. It drives new inputs just after the rising edge.
//   3. It queues the outputs that the model expects.
//
// A monitor on the falling edge takes each queued expectation and compares it
// with what both copies show.
// ---------------------------------------------------------------------------
module tb_regfile_2r1w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  dbg_addr;

    logic [31:0] rd1_b, rd2_b, dbg_b;
    logic [15:0] cnt_b;
    logic [31:0] rd1_n, rd2_n, dbg_n;
    logic [3:0]  cnt_n;

    int tests_run  = 0;
    int fail_count = 0;

    // Behavioural model: plain array of register contents plus a write tally.
    logic [31:0] model_mem [32];
    int          model_writes;

    typedef struct {
        logic [31:0] rd1_b;
        logic [31:0] rd2_b;
        logic [31:0] rd1_n;
        logic [31:0] rd2_n;
        logic [31:0] dbg;
        int          cnt_b;
        int          cnt_n;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .CNT_W(16)) dut_byp (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .dbg_addr(dbg_addr), .dbg_data(dbg_b), .wr_count(cnt_b)
    );

    regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .CNT_W(4)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .dbg_addr(dbg_addr), .dbg_data(dbg_n), .wr_count(cnt_n)
    );

    // Expected read value of one port, derived from the current inputs and the model.
    function automatic logic [31:0] modelRead(input logic [4:0] a, input bit fwd);
        if (a == 5'd0)                              return 32'h0;
        if (fwd && rst_n && we && (wa == a))        return wd;
        return model_mem[a];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests_run++;
        if (act !== expv) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic w, input logic [4:0] a,
                                 input logic [31:0] d, input logic [4:0] r1,
                                 input logic [4:0] r2, input logic [4:0] dbga);
        exp_t e;
        @(posedge clk);
        // The edge just taken commits the write driven during the previous cycle.
        if (rst_n && we && (wa != 5'd0)) begin
            model_mem[wa] = wd;
            model_writes++;
        end
        #1;
        rst_n = r; we = w; wa = a; wd = d; ra1 = r1; ra2 = r2; dbg_addr = dbga;
        if (!r) begin
            foreach (model_mem[i]) model_mem[i] = 32'h0;
            model_writes = 0;
        end
        e.rd1_b = modelRead(r1, 1'b1);
        e.rd2_b = modelRead(r2, 1'b1);
        e.rd1_n = modelRead(r1, 1'b0);
        e.rd2_n = modelRead(r2, 1'b0);
        e.dbg   = modelRead(dbga, 1'b0);
        e.cnt_b = (model_writes > 65535) ? 65535 : model_writes;
        e.cnt_n = (model_writes > 15) ? 15 : model_writes;
        exp_q.push_back(e);
    endtask

    // The monitor compares both copies against one queued expectation per falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("rd1_byp",      rd1_b,       mon_e.rd1_b);
            checkOutput("rd2_byp",      rd2_b,       mon_e.rd2_b);
            checkOutput("dbg_byp",      dbg_b,       mon_e.dbg);
            checkOutput("wr_count_byp", 32'(cnt_b),  32'(mon_e.cnt_b));
            checkOutput("rd1_nb",       rd1_n,       mon_e.rd1_n);
            checkOutput("rd2_nb",       rd2_n,       mon_e.rd2_n);
            checkOutput("dbg_nb",       dbg_n,       mon_e.dbg);
            checkOutput("wr_count_nb",  32'(cnt_n),  32'(mon_e.cnt_n));
        end
    end

    initial begin
        logic        r, w;
        logic [4:0]  a, r1, r2, dg;
        logic [31:0] d;
        int          waitCycles;

        rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; dbg_addr = '0;
        foreach (model_mem[i]) model_mem[i] = 32'h0;
        model_writes = 0;

        // Hold reset, then release it.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 5'd5);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd9, 5'd5);

        // Write reg5, read it back, then assert reset mid-cycle: the outputs drop at once.
        applyStimulus(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);

        // Basic write and read on both ports.
        applyStimulus(1'b1, 1'b1, 5'd8, 32'h12345678, 5'd1, 5'd2, 5'd8);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 5'd8);

        // A write to register 0 is ignored.
        applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd8, 5'd0);

        // Forwarding versus stored value, then both after the edge.
        applyStimulus(1'b1, 1'b1, 5'd3, 32'h00000001, 5'd0, 5'd0, 5'd3);
        applyStimulus(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 5'd3);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3);

        // Reset colliding with a write: the write is lost.
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h00000055, 5'd9, 5'd9, 5'd9);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 5'd9);

        // Counter saturation: 20 accepted writes, and the 4-bit counter holds at F.
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 5'((i % 31) + 1), 32'(i * 32'h01010101 + 7),
                          5'((i % 31) + 1), 5'(i % 31), 5'(i % 31));
        end
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd20, 5'd15);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd19, 5'd3);

        // Randomised traffic, with address collisions favoured and occasional resets.
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 63) != 0);
            w  = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            d  = $urandom;
            r1 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom);
            r2 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom);
            dg = ($urandom_range(0, 2) == 0) ? a : 5'($urandom);
            applyStimulus(r, w, a, d, r1, r2, dg);
        end

        waitCycles = 0;
        while (exp_q.size() > 0 && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            fail_count++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
